// File: rtl/cdb_arbiter_if.sv
// Bundle of producer handshakes and the common data bus shared by the
// cdb_arbiter and whatever drives its producer side.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH_BIT = 4
);
  logic                     alu_valid;
  logic [31:0]              alu_value;
  logic [ROB_WIDTH_BIT-1:0] alu_dest;
  logic [31:0]              alu_jalr_pc;
  logic                     alu_ready;

  logic                     ld_valid;
  logic [31:0]              ld_value;
  logic [ROB_WIDTH_BIT-1:0] ld_dest;
  logic                     ld_ready;

  logic                     st_valid;
  logic [ROB_WIDTH_BIT-1:0] st_dest;
  logic                     st_ready;

  logic                     cdb_valid;
  logic [1:0]               cdb_src;
  logic [31:0]              cdb_value;
  logic [ROB_WIDTH_BIT-1:0] cdb_dest;
  logic [31:0]              cdb_jalr_pc;

  // Round-robin pointer, exported for observation only.
  logic [1:0]               rr_ptr;

  modport master (
    output alu_valid, alu_value, alu_dest, alu_jalr_pc,
    output ld_valid, ld_value, ld_dest,
    output st_valid, st_dest,
    input  alu_ready, ld_ready, st_ready,
    input  cdb_valid, cdb_src, cdb_value, cdb_dest, cdb_jalr_pc, rr_ptr
  );

  modport slave (
    input  alu_valid, alu_value, alu_dest, alu_jalr_pc,
    input  ld_valid, ld_value, ld_dest,
    input  st_valid, st_dest,
    output alu_ready, ld_ready, st_ready,
    output cdb_valid, cdb_src, cdb_value, cdb_dest, cdb_jalr_pc, rr_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Three producer skid FIFOs drained round-robin, one entry per cycle, onto a
// registered common data bus feeding the ROB writeback and operand snoop.
module cdb_arbiter #(
  parameter int ROB_WIDTH_BIT = 4,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic clear_all,
  cdb_arbiter_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshake: a producer transfer happens on a posedge where x_valid and
  // x_ready are both high; x_ready never looks at the same-cycle pop.
  logic [2:0]               in_valid;
  logic [31:0]              in_value [3];
  logic [ROB_WIDTH_BIT-1:0] in_dest  [3];
  logic [31:0]              in_jalr  [3];

  logic [31:0]              val_mem  [3][FIFO_DEPTH];
  logic [ROB_WIDTH_BIT-1:0] dest_mem [3][FIFO_DEPTH];
  logic [31:0]              jalr_mem [3][FIFO_DEPTH];
  logic [AW-1:0]            head     [3];
  logic [AW-1:0]            tail     [3];
  logic [CW-1:0]            count    [3];

  logic [2:0] ready;
  logic [2:0] push;
  logic [2:0] pop;
  logic [1:0] rr_ptr;
  logic       grant_any;
  logic [1:0] grant_src;
  logic [1:0] next_rr;

  always_comb begin
    in_valid    = {bus.st_valid, bus.ld_valid, bus.alu_valid};
    in_value[0] = bus.alu_value;
    in_value[1] = bus.ld_value;
    in_value[2] = 32'd0;
    in_dest[0]  = bus.alu_dest;
    in_dest[1]  = bus.ld_dest;
    in_dest[2]  = bus.st_dest;
    in_jalr[0]  = bus.alu_jalr_pc;
    in_jalr[1]  = 32'd0;
    in_jalr[2]  = 32'd0;
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ready[k] = rdy_in && !clear_all && (count[k] != CW'(FIFO_DEPTH));
      push[k]  = in_valid[k] && ready[k];
    end
  end

  assign bus.alu_ready = ready[0];
  assign bus.ld_ready  = ready[1];
  assign bus.st_ready  = ready[2];
  assign bus.rr_ptr    = rr_ptr;

  function automatic logic [1:0] rot(input logic [1:0] p, input logic [1:0] i);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, i};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  always_comb begin
    logic [1:0] cand;
    cand      = 2'd0;
    grant_any = 1'b0;
    grant_src = 2'd0;
    if (rdy_in && !clear_all) begin
      for (int i = 0; i < 3; i++) begin
        cand = rot(rr_ptr, 2'(i));
        if (!grant_any && (count[cand] != '0)) begin
          grant_any = 1'b1;
          grant_src = cand;
        end
      end
    end
    next_rr = (grant_src == 2'd2) ? 2'd0 : grant_src + 2'd1;
    for (int k = 0; k < 3; k++) begin
      pop[k] = grant_any && (grant_src == 2'(k));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < 3; k++) begin
        head[k]  <= '0;
        tail[k]  <= '0;
        count[k] <= '0;
      end
      rr_ptr          <= 2'd0;
      bus.cdb_valid   <= 1'b0;
      bus.cdb_src     <= 2'd0;
      bus.cdb_value   <= 32'd0;
      bus.cdb_dest    <= '0;
      bus.cdb_jalr_pc <= 32'd0;
    end else if (rdy_in) begin
      if (clear_all) begin
        for (int k = 0; k < 3; k++) begin
          head[k]  <= '0;
          tail[k]  <= '0;
          count[k] <= '0;
        end
        rr_ptr        <= 2'd0;
        bus.cdb_valid <= 1'b0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (push[k]) begin
            val_mem[k][tail[k]]  <= in_value[k];
            dest_mem[k][tail[k]] <= in_dest[k];
            jalr_mem[k][tail[k]] <= in_jalr[k];
            tail[k]              <= tail[k] + AW'(1);
          end
          if (pop[k]) head[k] <= head[k] + AW'(1);
          case ({push[k], pop[k]})
            2'b10:   count[k] <= count[k] + CW'(1);
            2'b01:   count[k] <= count[k] - CW'(1);
            default: count[k] <= count[k];
          endcase
        end
        // Data outputs keep their last value on idle cycles.
        bus.cdb_valid <= grant_any;
        if (grant_any) begin
          bus.cdb_src     <= grant_src;
          bus.cdb_value   <= val_mem[grant_src][head[grant_src]];
          bus.cdb_dest    <= dest_mem[grant_src][head[grant_src]];
          bus.cdb_jalr_pc <= jalr_mem[grant_src][head[grant_src]];
          rr_ptr          <= next_rr;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Vector-table bench for cdb_arbiter: each row drives one cycle of producer
// inputs and queues the bus state expected after that edge.
module tb_cdb_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear_all;

  always #5 clk_in = ~clk_in;

  cdb_arbiter_if #(.ROB_WIDTH_BIT(4)) bus ();

  cdb_arbiter #(.ROB_WIDTH_BIT(4), .FIFO_DEPTH(2)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .clear_all (clear_all),
    .bus       (bus)
  );

  typedef struct {
    logic       rst, rdy, clr;
    logic       av;  logic [3:0] ad;
    logic       lv;  logic [3:0] ld;
    logic       sv;  logic [3:0] sd;
    logic [2:0] er;                 // {st,ld,alu} ready before the edge
    logic       ev;  logic [1:0] es; logic [3:0] ed;
    logic [1:0] err;                // rr_ptr after the edge
  } vec_t;

  vec_t vq[$];
  logic [71:0] exp_q[$];            // bit 71: compare full record
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] exp_value(input logic [1:0] s, input logic [3:0] d);
    if (s == 2'd0) return 32'hA000_0000 | {28'd0, d};
    if (s == 2'd1) return 32'hB000_0000 | {28'd0, d};
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_jalr(input logic [1:0] s, input logic [3:0] d);
    if (s == 2'd0) return 32'h0000_8000 | {28'd0, d};
    return 32'd0;
  endfunction

  function automatic logic [70:0] rec(input logic v, input logic [1:0] s, input logic [3:0] d,
                                      input logic [31:0] val, input logic [31:0] j);
    return {v, s, d, val, j};
  endfunction

  function automatic logic [70:0] act_rec();
    return {bus.cdb_valid, bus.cdb_src, bus.cdb_dest, bus.cdb_value, bus.cdb_jalr_pc};
  endfunction

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int rst, input int rdy, input int clr,
                     input int av, input int ad, input int lv, input int ld,
                     input int sv, input int sd, input int er,
                     input int ev, input int es, input int ed, input int err);
    vec_t v;
    v.rst = 1'(rst); v.rdy = 1'(rdy); v.clr = 1'(clr);
    v.av = 1'(av); v.ad = 4'(ad); v.lv = 1'(lv); v.ld = 4'(ld);
    v.sv = 1'(sv); v.sd = 4'(sd); v.er = 3'(er);
    v.ev = 1'(ev); v.es = 2'(es); v.ed = 4'(ed); v.err = 2'(err);
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_value = '0; bus.alu_dest = '0; bus.alu_jalr_pc = '0;
    bus.ld_valid = 1'b0;  bus.ld_value = '0;  bus.ld_dest = '0;
    bus.st_valid = 1'b0;  bus.st_dest = '0;
  endtask

  task automatic apply(input vec_t v);
    logic [71:0] e;
    rst_in = v.rst; rdy_in = v.rdy; clear_all = v.clr;
    bus.alu_valid = v.av; bus.alu_dest = v.ad;
    bus.alu_value = exp_value(2'd0, v.ad); bus.alu_jalr_pc = exp_jalr(2'd0, v.ad);
    bus.ld_valid = v.lv; bus.ld_dest = v.ld; bus.ld_value = exp_value(2'd1, v.ld);
    bus.st_valid = v.sv; bus.st_dest = v.sd;
    if (v.rst)     exp_q.push_back({1'b1, rec(1'b0, 2'd0, 4'd0, 32'd0, 32'd0)});
    else if (v.ev) exp_q.push_back({1'b1, rec(1'b1, v.es, v.ed, exp_value(v.es, v.ed), exp_jalr(v.es, v.ed))});
    else           exp_q.push_back({1'b0, rec(1'b0, 2'd0, 4'd0, 32'd0, 32'd0)});
    #1;
    check("ready", 71'({bus.st_ready, bus.ld_ready, bus.alu_ready}), 71'(v.er));
    @(posedge clk_in); #1;
    e = exp_q.pop_front();
    if (e[71]) check("cdb", act_rec(), e[70:0]);
    else       check("cdb_valid", 71'(bus.cdb_valid), 71'(e[70]));
    check("rr_ptr", 71'(bus.rr_ptr), 71'(v.err));
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_all = 1'b0;
    drive_idle();

    // Single ALU push, then idle: data must hold after cdb_valid drops.
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_value = 32'h1234; bus.alu_dest = 4'd3; bus.alu_jalr_pc = 32'h80;
    exp_q.push_back({1'b0, rec(1'b0, 2'd0, 4'd0, 32'd0, 32'd0)});
    exp_q.push_back({1'b1, rec(1'b1, 2'd0, 4'd3, 32'h1234, 32'h80)});
    exp_q.push_back({1'b1, rec(1'b0, 2'd0, 4'd3, 32'h1234, 32'h80)});
    @(posedge clk_in); #1;
    drive_idle();
    begin
      logic [71:0] e;
      for (int c = 0; c < 3; c++) begin
        if (c > 0) begin @(posedge clk_in); #1; end
        e = exp_q.pop_front();
        if (e[71]) check("single_alu", act_rec(), e[70:0]);
        else       check("single_alu_valid", 71'(bus.cdb_valid), 71'(e[70]));
      end
    end

    //   rst rdy clr  av ad  lv ld  sv sd   er      ev es ed  rr
    // Rotation with all three producers active from reset.
    add(1, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 0, 0, 0,  0);
    add(0, 1, 0,   1, 1,  1, 5,  1, 9,  3'b111, 0, 0, 0,  0);
    add(0, 1, 0,   1, 2,  1, 6,  1, 10, 3'b111, 1, 0, 1,  1);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b001, 1, 1, 5,  2);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b011, 1, 2, 9,  0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 0, 2,  1);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 1, 6,  2);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 2, 10, 0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 0, 0, 0,  0);
    // Load FIFO fills; the refused value 12 is retried and delivered once.
    add(0, 1, 0,   1, 3,  1, 7,  0, 0,  3'b111, 0, 0, 0,  0);
    add(0, 1, 0,   1, 4,  1, 8,  0, 0,  3'b111, 1, 0, 3,  1);
    add(0, 1, 0,   1, 11, 1, 12, 0, 0,  3'b101, 1, 1, 7,  2);
    add(0, 1, 0,   0, 0,  1, 12, 0, 0,  3'b110, 1, 0, 4,  1);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b101, 1, 1, 8,  2);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 0, 11, 1);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 1, 12, 2);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 0, 0, 0,  2);
    // Flush with pending entries and a same-cycle store push.
    add(0, 1, 0,   1, 1,  1, 2,  1, 3,  3'b111, 0, 0, 0,  2);
    add(0, 1, 0,   1, 4,  1, 5,  1, 6,  3'b111, 1, 2, 3,  0);
    add(0, 1, 0,   0, 0,  0, 0,  1, 7,  3'b100, 1, 0, 1,  1);
    add(0, 1, 1,   0, 0,  0, 0,  1, 8,  3'b000, 0, 0, 0,  0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 0, 0, 0,  0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 0, 0, 0,  0);
    // Pause while cdb_valid is high with dest 4; offered ALU value is ignored.
    add(0, 1, 0,   1, 4,  1, 5,  1, 6,  3'b111, 0, 0, 0,  0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 0, 4,  1);
    add(0, 0, 0,   1, 9,  0, 0,  0, 0,  3'b000, 1, 0, 4,  1);
    add(0, 0, 0,   1, 9,  0, 0,  0, 0,  3'b000, 1, 0, 4,  1);
    add(0, 0, 0,   1, 9,  0, 0,  0, 0,  3'b000, 1, 0, 4,  1);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 1, 5,  2);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 2, 6,  0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 0, 0, 0,  0);
    // Reset mid-stream, then src 0 wins first.
    add(0, 1, 0,   1, 1,  1, 2,  1, 3,  3'b111, 0, 0, 0,  0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 0, 1,  1);
    add(1, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 0, 0, 0,  0);
    add(0, 1, 0,   1, 7,  1, 8,  1, 9,  3'b111, 0, 0, 0,  0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 0, 7,  1);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 1, 8,  2);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 1, 2, 9,  0);
    add(0, 1, 0,   0, 0,  0, 0,  0, 0,  3'b111, 0, 0, 0,  0);

    foreach (vq[i]) apply(vq[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
